psr_branch_unit: RTL and testbench

- Consumer side of the processor status register: reads PSR flags, evaluates the 4-bit branch condition code, and owns the program counter.
- Resolves Bcond (PC-relative), Jcond (register target) and JAL (link) requests.
- Raises a one-cycle flush after any taken control transfer.
- Keeps a saturating count of taken transfers for debug.
- Sits between the decoder/controller and instruction memory addressing.

---
 rtl/psr_branch_unit_if.sv | 36 +++
 rtl/psr_branch_unit.sv | 132 +++++++++++++
 tb/tb_psr_branch_unit.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/psr_branch_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | psr_branch_unit_if: decoder <-> branch unit request and PC status bundle |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface psr_branch_unit_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
);
  logic [15:0]           psr;
  logic [3:0]            cond;
  logic                  pc_en;
  logic                  branch_req;
  logic                  jump_req;
  logic                  jal_req;
  logic [7:0]            disp;
  logic [ADDR_WIDTH-1:0] target;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] link_addr;
  logic                  taken;
  logic                  flush;
  logic [CNT_WIDTH-1:0]  taken_count;

  // Decoder / controller side
  modport master (
    output psr, cond, pc_en, branch_req, jump_req, jal_req, disp, target,
    input  pc, link_addr, taken, flush, taken_count
  );

  // Branch unit side
  modport slave (
    input  psr, cond, pc_en, branch_req, jump_req, jal_req, disp, target,
    output pc, link_addr, taken, flush, taken_count
  );
endinterface
`default_nettype wire

// File: rtl/psr_branch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | psr_branch_unit: PSR condition evaluation, PC ownership, Bcond/Jcond/JAL |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module psr_branch_unit #(
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    CNT_WIDTH  = 16
) (
  input  logic               clk,
  input  logic               reset,
  psr_branch_unit_if.slave   bus
);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] link_q, link_d;
  logic                  taken_q, taken_d;
  logic                  flush_q, flush_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic                  flag_c, flag_l, flag_f, flag_z, flag_n;
  logic                  cond_ok;
  logic                  take;
  logic [ADDR_WIDTH-1:0] disp_ext;
  logic                  psr_bits_unused;

  assign flag_c = bus.psr[0];
  assign flag_l = bus.psr[2];
  assign flag_f = bus.psr[5];
  assign flag_z = bus.psr[6];
  assign flag_n = bus.psr[7];
  assign psr_bits_unused = ^{bus.psr[15:8], bus.psr[4:3], bus.psr[1]};

  assign disp_ext = {{(ADDR_WIDTH-8){bus.disp[7]}}, bus.disp};

  always_comb begin
    cond_ok = 1'b0;
    case (bus.cond)
      4'b0000: cond_ok =  flag_z;
      4'b0001: cond_ok = ~flag_z;
      4'b0010: cond_ok =  flag_c;
      4'b0011: cond_ok = ~flag_c;
      4'b0100: cond_ok =  flag_l;
      4'b0101: cond_ok = ~flag_l;
      4'b0110: cond_ok =  flag_n;
      4'b0111: cond_ok = ~flag_n;
      4'b1000: cond_ok =  flag_f;
      4'b1001: cond_ok = ~flag_f;
      4'b1010: cond_ok = ~flag_l & ~flag_z;
      4'b1011: cond_ok =  flag_l |  flag_z;
      4'b1100: cond_ok = ~flag_n & ~flag_z;
      4'b1101: cond_ok =  flag_n |  flag_z;
      4'b1110: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    link_d  = link_q;
    taken_d = 1'b0;
    flush_d = 1'b0;
    cnt_d   = cnt_q;
    take    = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (bus.pc_en) begin
          if (bus.jal_req) begin
            link_d = pc_q + ADDR_WIDTH'(1);
            pc_d   = bus.target;
            take   = 1'b1;
          end else if (bus.jump_req && cond_ok) begin
            pc_d   = bus.target;
            take   = 1'b1;
          end else if (bus.branch_req && cond_ok) begin
            pc_d   = pc_q + disp_ext;
            take   = 1'b1;
          end else begin
            pc_d   = pc_q + ADDR_WIDTH'(1);
          end
        end
      end
      // The flush slot ignores every request, even with pc_en low.
      ST_FLUSH: state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase

    if (take) begin
      state_d = ST_FLUSH;
      taken_d = 1'b1;
      flush_d = 1'b1;
      if (cnt_q != {CNT_WIDTH{1'b1}}) begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      link_q  <= '0;
      taken_q <= 1'b0;
      flush_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      link_q  <= link_d;
      taken_q <= taken_d;
      flush_q <= flush_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.link_addr   = link_q;
  assign bus.taken       = taken_q;
  assign bus.flush       = flush_q;
  assign bus.taken_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_psr_branch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_psr_branch_unit: directed self-checking bench for psr_branch_unit     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_psr_branch_unit;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [3:0] exp_cnt;

  psr_branch_unit_if #(.ADDR_WIDTH(16), .CNT_WIDTH(4)) bus ();

  psr_branch_unit #(
    .ADDR_WIDTH (16),
    .RESET_PC   (16'h0000),
    .CNT_WIDTH  (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic br, input logic jp, input logic jl,
                       input logic [3:0] c, input logic [7:0] d, input logic [15:0] t);
    bus.pc_en      = en;
    bus.branch_req = br;
    bus.jump_req   = jp;
    bus.jal_req    = jl;
    bus.cond       = c;
    bus.disp       = d;
    bus.target     = t;
  endtask

  task automatic bump_cnt();
    if (exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
  endtask

  // Unconditional jump to t, then let the flush slot pass.
  task automatic go_to(input logic [15:0] t);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 4'b1110, 8'h00, t);
    cycle();
    bump_cnt();
    check("goto_pc", bus.pc, t);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 8'h00, 16'h0000);
    cycle();
    check("goto_pc_hold", bus.pc, t);
  endtask

  logic [15:0] psr_sat [16];
  logic [15:0] psr_vio [16];
  logic        exp_tk;
  logic [15:0] noise;

  initial begin
    checks  = 0;
    errors  = 0;
    exp_cnt = 4'd0;
    noise   = 16'hFF1A;
    psr_sat = '{16'h0040, 16'h0000, 16'h0001, 16'h0000, 16'h0004, 16'h0000, 16'h0080, 16'h0000,
                16'h0020, 16'h0000, 16'h0000, 16'h0004, 16'h0000, 16'h0040, 16'h0000, 16'hFFFF};
    psr_vio = '{16'h0000, 16'h0040, 16'h0000, 16'h0001, 16'h0000, 16'h0004, 16'h0000, 16'h0080,
                16'h0000, 16'h0020, 16'h0040, 16'h0000, 16'h0080, 16'h0000, 16'hFFFF, 16'h0000};

    reset   = 1'b0;
    bus.psr = 16'h0000;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 8'h00, 16'h0000);
    #2;
    check("rst_pc", bus.pc, 16'h0000);
    check("rst_link", bus.link_addr, 16'h0000);
    check("rst_taken", bus.taken, 1'b0);
    check("rst_flush", bus.flush, 1'b0);
    check("rst_cnt", bus.taken_count, 4'd0);
    cycle();
    reset = 1'b1;

    // Async reset while in the flush slot
    drive(1'b1, 1'b0, 1'b1, 1'b0, 4'b1110, 8'h00, 16'h0040);
    cycle();
    check("pre_rst_pc", bus.pc, 16'h0040);
    check("pre_rst_flush", bus.flush, 1'b1);
    check("pre_rst_cnt", bus.taken_count, 4'd1);
    reset = 1'b0;
    #1;
    check("async_rst_pc", bus.pc, 16'h0000);
    check("async_rst_flush", bus.flush, 1'b0);
    check("async_rst_taken", bus.taken, 1'b0);
    check("async_rst_cnt", bus.taken_count, 4'd0);
    #1;
    reset = 1'b1;

    // Sequential advance, then hold
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 8'h00, 16'h0000);
    for (int i = 1; i <= 3; i++) begin
      cycle();
      check($sformatf("seq_pc_%0d", i), bus.pc, 16'(i));
      check($sformatf("seq_taken_%0d", i), bus.taken, 1'b0);
    end
    drive(1'b0, 1'b1, 1'b1, 1'b1, 4'b1110, 8'h10, 16'h0500);
    for (int i = 0; i < 2; i++) begin
      cycle();
      check($sformatf("hold_pc_%0d", i), bus.pc, 16'h0003);
      check($sformatf("hold_taken_%0d", i), bus.taken, 1'b0);
    end

    // Bcond sweep over all condition codes, satisfied then violated
    for (int c = 0; c < 16; c++) begin
      for (int s = 1; s >= 0; s--) begin
        go_to(16'h0010);
        bus.psr = ((s == 1) ? psr_sat[c] : psr_vio[c]) | noise;
        if (c == 14 || c == 15) bus.psr = (s == 1) ? psr_sat[c] : psr_vio[c];
        exp_tk = (c == 14) || (s == 1 && c != 15);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'(c), 8'hFE, 16'h0000);
        cycle();
        if (exp_tk) bump_cnt();
        check($sformatf("bc%0d_s%0d_pc", c, s), bus.pc, exp_tk ? 16'h000E : 16'h0011);
        check($sformatf("bc%0d_s%0d_taken", c, s), bus.taken, exp_tk);
        check($sformatf("bc%0d_s%0d_flush", c, s), bus.flush, exp_tk);
        check($sformatf("bc%0d_s%0d_cnt", c, s), bus.taken_count, exp_cnt);
        if (exp_tk) begin
          cycle();
          check($sformatf("bc%0d_flush_pc", c), bus.pc, 16'h000E);
          check($sformatf("bc%0d_flush_end", c), bus.flush, 1'b0);
          check($sformatf("bc%0d_taken_end", c), bus.taken, 1'b0);
        end
        bus.psr = 16'h0000;
      end
    end

    // JAL beats jump and branch; requests in the flush slot are dropped
    go_to(16'h0020);
    bus.psr = 16'h0000;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 4'b1111, 8'h05, 16'h0100);
    cycle();
    bump_cnt();
    check("jal_pc", bus.pc, 16'h0100);
    check("jal_link", bus.link_addr, 16'h0021);
    check("jal_taken", bus.taken, 1'b1);
    check("jal_flush", bus.flush, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 4'b1110, 8'h05, 16'h0200);
    cycle();
    check("jal_flush_pc", bus.pc, 16'h0100);
    check("jal_flush_link", bus.link_addr, 16'h0021);
    check("jal_flush_taken", bus.taken, 1'b0);
    check("jal_flush_end", bus.flush, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 4'b1110, 8'h10, 16'h0300);
    cycle();
    bump_cnt();
    check("jmp_over_br_pc", bus.pc, 16'h0300);
    check("jmp_link_kept", bus.link_addr, 16'h0021);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 8'h00, 16'h0000);
    cycle();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 8'h00, 16'h0700);
    cycle();
    check("jmp_false_pc", bus.pc, 16'h0301);
    check("jmp_false_taken", bus.taken, 1'b0);

    // Wrap-around
    go_to(16'hFFFF);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 8'h00, 16'h0000);
    cycle();
    check("wrap_seq_pc", bus.pc, 16'h0000);
    go_to(16'h0002);
    bus.psr = 16'h0040;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 8'h80, 16'h0000);
    cycle();
    bump_cnt();
    check("wrap_neg_pc", bus.pc, 16'hFF82);
    check("wrap_neg_taken", bus.taken, 1'b1);
    bus.psr = 16'h0000;

    // Counter saturation from a clean reset
    reset = 1'b0;
    #1;
    reset = 1'b1;
    exp_cnt = 4'd0;
    for (int i = 1; i <= 17; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 4'b1110, 8'h02, 16'h0000);
      cycle();
      bump_cnt();
      check($sformatf("sat_pc_%0d", i), bus.pc, 16'(2 * i));
      check($sformatf("sat_cnt_%0d", i), bus.taken_count, exp_cnt);
      cycle();
    end
    check("sat_final", bus.taken_count, 4'd15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
